result_out: RTL and testbench
=============================

# result_out

Transmit-side serializer for the SPI link. On a start pulse it reads a word region out of scratch memory and streams it to the SPI byte transmitter as one framed packet: header byte, 32-bit word count (LSB first), then each 32-bit word LSB first. It sits between the result scratch memory and the SPI slave transmit shift register. It is the outbound counterpart of the command-input path, using the same framing.

## Interface
- ADDR_W, default `ADDR_SIZE: memory address width.
- HEADER, default 8'h02: packet header byte (the command path uses 8'h01).
- clk  in  1  clock
- rst_L  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a packet; ignored while busy
- region_begin  in  ADDR_W  first word address, sampled at start
- region_end  in  ADDR_W  one past the last word address, sampled at start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the packet is complete
- mem_rd  out  1  one-cycle read request pulse
- mem_addr  out  ADDR_W  read address, valid with mem_rd
- mem_rd_done  in  1  one-cycle pulse; read data is valid
- mem_rd_data  in  32  read data, qualified by mem_rd_done
- byte_send  out  8  byte to transmit
- send_valid  out  1  byte_send is valid
- send_ready  in  1  transmitter accepts the byte; a transfer occurs when send_valid && send_ready

## Operation
- States: IDLE, HEADER, COUNT, FETCH, WAIT_MEM, SEND.
- IDLE, start=1:
  - latch base=region_begin and count=(region_end-region_begin) mod 2^ADDR_W, zero-extended to 32 bits;
  - go to HEADER.
- HEADER: drive byte_send=HEADER, send_valid=1. On transfer, go to COUNT with byte index 0.
- COUNT: drive count[8*i+:8] for i=0..3. On the transfer of i=3:
  - if count==0, pulse done and go to IDLE;
  - otherwise go to FETCH with addr=base and words_left=count.
- FETCH: pulse mem_rd for exactly one cycle with mem_addr=addr, then go to WAIT_MEM.
- WAIT_MEM: on mem_rd_done, latch mem_rd_data into word_buf and go to SEND with byte index 0. Read latency is unbounded.
- SEND: drive word_buf[8*i+:8]. On the transfer of i=3, decrement words_left. Then:
  - if words_left becomes 0, pulse done and go to IDLE;
  - else set addr=addr+1 (wraps mod 2^ADDR_W) and go to FETCH.
- Handshake rules:
  - send_valid, once raised, stays high with byte_send stable until the transfer;
  - send_valid is low in IDLE, FETCH and WAIT_MEM;
  - the block never issues a second mem_rd while a read is outstanding;
  - a mem_rd_done outside WAIT_MEM is ignored.
- start while busy is ignored; region inputs are not re-sampled.
- Reset is asynchronous at any point, including mid-packet: go to IDLE, abandon any outstanding read, and drop the packet. The transmitter side must resynchronize on the next header.

## Timing
- Reset values:
  - busy=0, done=0, mem_rd=0, mem_addr=0, send_valid=0, byte_send=0;
  - state=IDLE, all counters and word_buf=0.
- Start sampled in cycle t: busy=1 and send_valid=1 (header) in t+1.
- If send_ready is held high, one byte transfers per cycle.
- mem_rd fires the cycle after the last count byte, or after the last byte of the previous word, is accepted.
- First data byte is presented the cycle after mem_rd_done.
- done is asserted in the cycle after the final transfer. busy falls in the same cycle. A new start is accepted in that cycle.
- Minimum packet length is 5 transfers plus 4 transfers per word.
- Per-word overhead is 2 + L cycles for memory latency L.

## Structure
- Shared package spi_pkg holds:
  - the HEADER constants CMD_HEADER=8'h01 and RES_HEADER=8'h02;
  - the state enum type;
  - BYTES_PER_WORD=4.
- Sub-module word_serializer: 32-bit load plus valid/ready byte output, LSB first, with a last-byte flag. It is used for both COUNT and SEND. The top-level FSM owns the memory and framing logic.

## Test plan
- start with region 0x10..0x10 (count 0), send_ready=1 -> bytes 02 00 00 00 00; no mem_rd; done in the cycle after the 5th transfer.
- region 0x04..0x06, memory {0x04:0xDEADBEEF, 0x05:0x01020304}, latency 1 -> mem_rd addresses 4, 5 only; bytes 02 02 00 00 00 EF BE AD DE 04 03 02 01; single done.
- Same packet with send_ready random 30% duty and memory latency 0–7 random -> identical byte stream; byte_send stable while send_valid && !send_ready; never more than one read outstanding.
- region_begin=2^ADDR_W-1, region_end=1 -> count 2; mem_addr sequence 2^ADDR_W-1 then 0.
- start pulses during busy, and a stray mem_rd_done in SEND -> ignored; stream unchanged.
- rst_L asserted mid-word (after 2 data bytes) -> all outputs 0 immediately; a subsequent start produces a complete, fresh packet.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared SPI link framing constants and serializer FSM state type.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

package spi_pkg;

    localparam int ADDR_W_DEFAULT = `ADDR_SIZE;

    localparam logic [7:0] CMD_HEADER = 8'h01;
    localparam logic [7:0] RES_HEADER = 8'h02;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_COUNT    = 3'd2,
        ST_FETCH    = 3'd3,
        ST_WAIT_MEM = 3'd4,
        ST_SEND     = 3'd5
    } state_e;

    // Byte lane i of a 32-bit word, lane 0 being the least significant.
    function automatic logic [7:0] byte_lane(input logic [31:0] w,
                                             input logic [BYTE_IDX_W-1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/result_out_if.sv
`default_nettype none
// ============================================================================
// Module   : result_out_if
// Brief    : Control, scratch-memory read and SPI byte-send signals of the
//            result serializer; master is the serializer side.
// Revision : 1.0 - initial release
// ============================================================================

interface result_out_if
    import spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              start;
    logic [ADDR_W-1:0] region_begin;
    logic [ADDR_W-1:0] region_end;
    logic              busy;
    logic              done;

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_done;
    logic [31:0]       mem_rd_data;

    logic [7:0]        byte_send;
    logic              send_valid;
    logic              send_ready;

    modport master (
        input  start, region_begin, region_end, mem_rd_done, mem_rd_data, send_ready,
        output busy, done, mem_rd, mem_addr, byte_send, send_valid
    );

    modport slave (
        output start, region_begin, region_end, mem_rd_done, mem_rd_data, send_ready,
        input  busy, done, mem_rd, mem_addr, byte_send, send_valid
    );

endinterface

`default_nettype wire

// File: rtl/result_out_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : word_serializer
// Brief    : Loads a 32-bit word and emits it LSB first as valid/ready bytes.
// Revision : 1.0 - initial release
// ============================================================================

module word_serializer
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_L,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        ready_i,
    output logic [7:0]  byte_o,
    output logic        valid_o,
    output logic        last_o
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [31:0]           word_q, word_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic                  valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load_i) begin
            word_d  = data_i;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            if (idx_q == LAST_IDX) begin
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q + BYTE_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign byte_o  = byte_lane(word_q, idx_q);
    assign valid_o = valid_q;
    assign last_o  = valid_q && (idx_q == LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/result_out.sv
`default_nettype none
// ============================================================================
// Module   : result_out
// Brief    : Streams a scratch-memory word region to the SPI transmitter as
//            header, 32-bit word count and data words, all LSB first.
// Revision : 1.0 - initial release
// ============================================================================

module result_out
    import spi_pkg::*;
#(
    parameter int         ADDR_W = ADDR_W_DEFAULT,
    parameter logic [7:0] HEADER = RES_HEADER
)
(
    input  logic          clk,
    input  logic          rst_L,
    result_out_if.master  res_if
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       left_q, left_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] w_span;
    logic              w_ser_load;
    logic [31:0]       w_ser_data;
    logic [7:0]        w_ser_byte;
    logic              w_ser_valid;
    logic              w_ser_last;
    logic              w_ser_end;

    // Region length wraps modulo the address space, so end < begin is legal.
    assign w_span    = res_if.region_end - res_if.region_begin;
    assign w_ser_end = w_ser_last && res_if.send_ready;

    word_serializer u_ser (
        .clk     (clk),
        .rst_L   (rst_L),
        .load_i  (w_ser_load),
        .data_i  (w_ser_data),
        .ready_i (res_if.send_ready),
        .byte_o  (w_ser_byte),
        .valid_o (w_ser_valid),
        .last_o  (w_ser_last)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        addr_d     = addr_q;
        count_d    = count_q;
        left_d     = left_q;
        done_d     = 1'b0;
        w_ser_load = 1'b0;
        w_ser_data = count_q;
        case (state_q)
            ST_IDLE: begin
                if (res_if.start) begin
                    base_d  = res_if.region_begin;
                    count_d = 32'(w_span);
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (res_if.send_ready) begin
                    w_ser_load = 1'b1;
                    state_d    = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_ser_end) begin
                    if (count_q == 32'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = base_q;
                        left_d  = count_q;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                if (res_if.mem_rd_done) begin
                    w_ser_load = 1'b1;
                    w_ser_data = res_if.mem_rd_data;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_ser_end) begin
                    left_d = left_q - 32'd1;
                    if (left_q == 32'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
            left_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            left_q  <= left_d;
            done_q  <= done_d;
        end
    end

    // Serializer holds its last word after a packet; mask it so idle reads zero.
    assign res_if.busy       = (state_q != ST_IDLE);
    assign res_if.done       = done_q;
    assign res_if.mem_rd     = (state_q == ST_FETCH);
    assign res_if.mem_addr   = addr_q;
    assign res_if.send_valid = (state_q == ST_HEADER) || w_ser_valid;
    assign res_if.byte_send  = (state_q == ST_HEADER) ? HEADER :
                               (w_ser_valid ? w_ser_byte : 8'h00);

endmodule

`default_nettype wire

// File: tb/tb_result_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_out
// Brief    : Directed self-checking bench for the result_out serializer.
// Revision : 1.0 - initial release
// ============================================================================

module tb_result_out;
    import spi_pkg::*;

    localparam int AW = 8;

    logic clk   = 1'b0;
    logic rst_L = 1'b1;
    always #5 clk = ~clk;

    result_out_if #(.ADDR_W(AW)) bus ();

    result_out #(.ADDR_W(AW), .HEADER(RES_HEADER)) dut (
        .clk    (clk),
        .rst_L  (rst_L),
        .res_if (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [7:0]    main_exp [0:12];
    logic [7:0]    xfers [$];
    logic [AW-1:0] rd_addrs [$];

    // Environment state, written only by the negedge process below
    int            cyc = 0, done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0;
    int            stab_err = 0, ovl_err = 0, busy_done_err = 0, stray_done = 0;
    int            lat_cnt = 0, rd_since_done = 0;
    bit            outstanding = 1'b0, stall_prev = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [7:0]    prev_byte = 8'h00;

    // Environment controls, written only by the test sequence
    bit ready_rand = 1'b0, lat_rand = 1'b0;
    int lat_fixed = 1, stray_req = 0;

    // Memory responder, SPI transmitter and protocol monitors; outputs are
    // sampled and inputs changed on the falling edge.
    always @(negedge clk) begin
        cyc++;
        bus.mem_rd_done = 1'b0;
        if (!rst_L) begin
            outstanding   = 1'b0;
            stall_prev    = 1'b0;
            rd_since_done = 0;
        end else begin
            if (outstanding) begin
                if (lat_cnt == 0) begin
                    bus.mem_rd_done = 1'b1;
                    bus.mem_rd_data = mem[pend_addr];
                    outstanding     = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end else if (stray_req > stray_done && rd_since_done > 0 && bus.send_valid) begin
                bus.mem_rd_done = 1'b1;
                bus.mem_rd_data = 32'hBAD0_BAD0;
                stray_done++;
            end
            if (bus.mem_rd) begin
                if (outstanding) ovl_err++;
                rd_addrs.push_back(bus.mem_addr);
                pend_addr   = bus.mem_addr;
                outstanding = 1'b1;
                lat_cnt     = lat_rand ? int'($urandom_range(0, 7)) : lat_fixed;
                rd_since_done++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc      = cyc;
                rd_since_done = 0;
                if (bus.busy) busy_done_err++;
            end
            if (stall_prev && (!bus.send_valid || bus.byte_send !== prev_byte)) stab_err++;
            bus.send_ready = ready_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (bus.send_valid && bus.send_ready) begin
                xfers.push_back(bus.byte_send);
                last_xfer_cyc = cyc;
            end
            stall_prev = bus.send_valid && !bus.send_ready;
            prev_byte  = bus.byte_send;
        end
    end

    task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] e, output int s);
        @(negedge clk);
        bus.region_begin = b;
        bus.region_end   = e;
        bus.start        = 1'b1;
        #1 s = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, input bit spam, output bit ok);
        int n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk);
            if (spam && bus.busy) begin
                bus.start        = 1'b1;
                bus.region_begin = 8'h80;
                bus.region_end   = 8'h90;
            end else begin
                bus.start = 1'b0;
            end
            #1 n++;
        end
        ok = (done_cnt != d0);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.region_begin = '0;
        bus.region_end   = '0;
        #1 rst_L = 1'b0;
        #2;
        total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0)       begin bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
        total++; if (bus.mem_rd !== 1'b0)     begin bad++; $display("FAIL rst_mem_rd: got %b want 0", bus.mem_rd); end
        total++; if (bus.mem_addr !== '0)     begin bad++; $display("FAIL rst_mem_addr: got %h want 00", bus.mem_addr); end
        total++; if (bus.send_valid !== 1'b0) begin bad++; $display("FAIL rst_send_valid: got %b want 0", bus.send_valid); end
        total++; if (bus.byte_send !== 8'h00) begin bad++; $display("FAIL rst_byte_send: got %h want 00", bus.byte_send); end
        repeat (3) @(negedge clk);
        rst_L = 1'b1;
    endtask

    task automatic test_empty();
        logic [7:0] e [0:4];
        int xb, rb, d0, s;
        bit ok;
        e = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
        ready_rand = 1'b0; lat_rand = 1'b0;
        xb = xfers.size(); rb = rd_addrs.size(); d0 = done_cnt;
        launch(8'h10, 8'h10, s);
        #1;
        total++; if (bus.busy !== 1'b1)       begin bad++; $display("FAIL empty_busy_t1: got %b want 1", bus.busy); end
        total++; if (bus.send_valid !== 1'b1) begin bad++; $display("FAIL empty_valid_t1: got %b want 1", bus.send_valid); end
        total++; if (bus.byte_send !== 8'h02) begin bad++; $display("FAIL empty_header: got %h want 02", bus.byte_send); end
        wait_done(d0, 200, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL empty_timeout: got no done want done"); end
        repeat (4) @(negedge clk);
        #1;
        total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL empty_done_count: got %0d want %0d", done_cnt - d0, 1); end
        total++; if (done_cyc !== s + 6)  begin bad++; $display("FAIL empty_done_cycle: got %0d want %0d", done_cyc - s, 6); end
        total++; if (busy_done_err !== 0) begin bad++; $display("FAIL empty_busy_at_done: got %0d want 0", busy_done_err); end
        total++; if (rd_addrs.size() !== rb) begin bad++; $display("FAIL empty_no_read: got %0d reads want 0", rd_addrs.size() - rb); end
        total++; if (xfers.size() - xb !== 5) begin bad++; $display("FAIL empty_len: got %0d want 5", xfers.size() - xb); end
        for (int i = 0; i < 5; i++) begin
            if (xb + i < xfers.size()) begin
                total++;
                if (xfers[xb+i] !== e[i]) begin bad++; $display("FAIL empty_byte[%0d]: got %h want %h", i, xfers[xb+i], e[i]); end
            end
        end
    endtask

    task automatic test_two_words();
        int xb, rb, d0, s;
        bit ok;
        ready_rand = 1'b0; lat_rand = 1'b0; lat_fixed = 1;
        xb = xfers.size(); rb = rd_addrs.size(); d0 = done_cnt;
        launch(8'h04, 8'h06, s);
        wait_done(d0, 400, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL two_timeout: got no done want done"); end
        repeat (4) @(negedge clk);
        #1;
        total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL two_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (done_cyc !== s + 20) begin bad++; $display("FAIL two_done_cycle: got %0d want 20", done_cyc - s); end
        total++; if (done_cyc !== last_xfer_cyc + 1) begin bad++; $display("FAIL two_done_after_last: got %0d want 1", done_cyc - last_xfer_cyc); end
        total++; if (rd_addrs.size() - rb !== 2) begin bad++; $display("FAIL two_reads: got %0d want 2", rd_addrs.size() - rb); end
        if (rd_addrs.size() - rb >= 2) begin
            total++; if (rd_addrs[rb] !== 8'h04)   begin bad++; $display("FAIL two_addr0: got %h want 04", rd_addrs[rb]); end
            total++; if (rd_addrs[rb+1] !== 8'h05) begin bad++; $display("FAIL two_addr1: got %h want 05", rd_addrs[rb+1]); end
        end
        total++; if (xfers.size() - xb !== 13) begin bad++; $display("FAIL two_len: got %0d want 13", xfers.size() - xb); end
        for (int i = 0; i < 13; i++) begin
            if (xb + i < xfers.size()) begin
                total++;
                if (xfers[xb+i] !== main_exp[i]) begin bad++; $display("FAIL two_byte[%0d]: got %h want %h", i, xfers[xb+i], main_exp[i]); end
            end
        end
    endtask

    task automatic test_random_stall();
        int xb, rb, d0, s, se, oe;
        bit ok;
        ready_rand = 1'b1; lat_rand = 1'b1;
        xb = xfers.size(); rb = rd_addrs.size(); d0 = done_cnt; se = stab_err; oe = ovl_err;
        launch(8'h04, 8'h06, s);
        wait_done(d0, 2000, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_timeout: got no done want done"); end
        ready_rand = 1'b0; lat_rand = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL rand_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (stab_err !== se) begin bad++; $display("FAIL rand_stable: got %0d violations want 0", stab_err - se); end
        total++; if (ovl_err !== oe)  begin bad++; $display("FAIL rand_one_read: got %0d overlaps want 0", ovl_err - oe); end
        total++; if (rd_addrs.size() - rb !== 2) begin bad++; $display("FAIL rand_reads: got %0d want 2", rd_addrs.size() - rb); end
        total++; if (xfers.size() - xb !== 13) begin bad++; $display("FAIL rand_len: got %0d want 13", xfers.size() - xb); end
        for (int i = 0; i < 13; i++) begin
            if (xb + i < xfers.size()) begin
                total++;
                if (xfers[xb+i] !== main_exp[i]) begin bad++; $display("FAIL rand_byte[%0d]: got %h want %h", i, xfers[xb+i], main_exp[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e [0:12];
        int xb, rb, d0, s;
        bit ok;
        e = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
              8'h0D, 8'hF0, 8'hFE, 8'hCA};
        ready_rand = 1'b0; lat_rand = 1'b0; lat_fixed = 0;
        xb = xfers.size(); rb = rd_addrs.size(); d0 = done_cnt;
        launch(8'hFF, 8'h01, s);
        wait_done(d0, 400, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got no done want done"); end
        total++; if (rd_addrs.size() - rb !== 2) begin bad++; $display("FAIL wrap_reads: got %0d want 2", rd_addrs.size() - rb); end
        if (rd_addrs.size() - rb >= 2) begin
            total++; if (rd_addrs[rb] !== 8'hFF)   begin bad++; $display("FAIL wrap_addr0: got %h want ff", rd_addrs[rb]); end
            total++; if (rd_addrs[rb+1] !== 8'h00) begin bad++; $display("FAIL wrap_addr1: got %h want 00", rd_addrs[rb+1]); end
        end
        total++; if (xfers.size() - xb !== 13) begin bad++; $display("FAIL wrap_len: got %0d want 13", xfers.size() - xb); end
        for (int i = 0; i < 13; i++) begin
            if (xb + i < xfers.size()) begin
                total++;
                if (xfers[xb+i] !== e[i]) begin bad++; $display("FAIL wrap_byte[%0d]: got %h want %h", i, xfers[xb+i], e[i]); end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int xb, rb, d0, s, sd;
        bit ok;
        ready_rand = 1'b0; lat_rand = 1'b0; lat_fixed = 2;
        xb = xfers.size(); rb = rd_addrs.size(); d0 = done_cnt; sd = stray_done;
        stray_req++;
        launch(8'h04, 8'h06, s);
        wait_done(d0, 400, 1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_timeout: got no done want done"); end
        repeat (6) @(negedge clk);
        #1;
        total++; if (stray_done !== sd + 1) begin bad++; $display("FAIL ign_stray_sent: got %0d want 1", stray_done - sd); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_no_restart: got busy=%b want 0", bus.busy); end
        total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (rd_addrs.size() - rb !== 2) begin bad++; $display("FAIL ign_reads: got %0d want 2", rd_addrs.size() - rb); end
        if (rd_addrs.size() - rb >= 2) begin
            total++; if (rd_addrs[rb+1] !== 8'h05) begin bad++; $display("FAIL ign_addr1: got %h want 05", rd_addrs[rb+1]); end
        end
        total++; if (xfers.size() - xb !== 13) begin bad++; $display("FAIL ign_len: got %0d want 13", xfers.size() - xb); end
        for (int i = 0; i < 13; i++) begin
            if (xb + i < xfers.size()) begin
                total++;
                if (xfers[xb+i] !== main_exp[i]) begin bad++; $display("FAIL ign_byte[%0d]: got %h want %h", i, xfers[xb+i], main_exp[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int xb, rb, d0, s, n;
        bit ok;
        ready_rand = 1'b0; lat_rand = 1'b0; lat_fixed = 1;
        xb = xfers.size(); d0 = done_cnt;
        launch(8'h04, 8'h06, s);
        n = 0;
        while (xfers.size() - xb < 7 && n < 200) begin
            @(negedge clk);
            #1 n++;
        end
        total++; if (xfers.size() - xb < 7) begin bad++; $display("FAIL mid_reach: got %0d bytes want 7", xfers.size() - xb); end
        @(posedge clk);
        #2 rst_L = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        total++; if (bus.mem_addr !== '0)     begin bad++; $display("FAIL mid_mem_addr: got %h want 00", bus.mem_addr); end
        total++; if (bus.send_valid !== 1'b0) begin bad++; $display("FAIL mid_send_valid: got %b want 0", bus.send_valid); end
        total++; if (bus.byte_send !== 8'h00) begin bad++; $display("FAIL mid_byte_send: got %h want 00", bus.byte_send); end
        total++; if (bus.mem_rd !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL mid_rd_done: got %b%b want 00", bus.mem_rd, bus.done); end
        repeat (3) @(negedge clk);
        rst_L = 1'b1;
        #1;
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - d0); end
        xb = xfers.size(); rb = rd_addrs.size(); d0 = done_cnt;
        launch(8'h04, 8'h06, s);
        wait_done(d0, 400, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_timeout: got no done want done"); end
        total++; if (done_cyc !== s + 20) begin bad++; $display("FAIL mid_done_cycle: got %0d want 20", done_cyc - s); end
        total++; if (rd_addrs.size() - rb !== 2) begin bad++; $display("FAIL mid_reads: got %0d want 2", rd_addrs.size() - rb); end
        total++; if (xfers.size() - xb !== 13) begin bad++; $display("FAIL mid_len: got %0d want 13", xfers.size() - xb); end
        for (int i = 0; i < 13; i++) begin
            if (xb + i < xfers.size()) begin
                total++;
                if (xfers[xb+i] !== main_exp[i]) begin bad++; $display("FAIL mid_byte[%0d]: got %h want %h", i, xfers[xb+i], main_exp[i]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[8'h04] = 32'hDEAD_BEEF;
        mem[8'h05] = 32'h0102_0304;
        mem[8'hFF] = 32'h1122_3344;
        mem[8'h00] = 32'hCAFE_F00D;
        main_exp = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                     8'h04, 8'h03, 8'h02, 8'h01};
        test_reset();
        test_empty();
        test_two_words();
        test_random_stall();
        test_wrap();
        test_busy_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire
